// File: rtl/boot_pkg.sv
// ----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the UART boot loader: the load/handover state
// encoding and the default handshake bytes and IMEM geometry.
// No ports (package).
// ----------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        S_READY,   // announce readiness to the host
        S_TXWAIT,  // one-cycle guard while UartTx raises busy
        S_SIZE,    // collect the 4-byte little-endian program size
        S_PROG,    // collect program bytes and write packed words
        S_ACK,     // announce completion to the host
        S_DONE     // UART handed over to the CPU
    } boot_state_t;

    localparam int          IMEM_ADDR_WIDTH_DEF = 15;
    localparam logic [7:0]  READY_BYTE_DEF      = 8'h99;
    localparam logic [7:0]  ACK_BYTE_DEF        = 8'haa;

endpackage

// File: rtl/word_packer.sv
// ----------------------------------------------------------------------------
// word_packer
// Assembles bytes little-endian into a 32-bit word and emits it with a
// one-cycle write strobe in the cycle after the flushing byte.
// Ports:
//   clock, resetn      clock, synchronous active-low reset
//   i_strobe           byte valid this cycle
//   i_lane   [1:0]     byte lane the incoming byte lands in
//   i_byte   [7:0]     incoming byte
//   i_flush            emit the word (including this byte) next cycle
//   i_clear            discard any partially packed word
//   o_word   [31:0]    last emitted word (held until the next flush)
//   o_we               one-cycle strobe qualifying o_word
// ----------------------------------------------------------------------------
module word_packer (
    input  logic        clock,
    input  logic        resetn,
    input  logic        i_strobe,
    input  logic [1:0]  i_lane,
    input  logic [7:0]  i_byte,
    input  logic        i_flush,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_we
);

    logic [31:0] r_buf;
    logic [31:0] r_word;
    logic        r_we;
    logic [31:0] w_merged;

    // NOTE: every variable written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_merged = r_buf;
        w_merged[{i_lane, 3'b000} +: 8] = i_byte;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_buf  <= '0;
            r_word <= '0;
            r_we   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (i_clear) begin
                r_buf <= '0;
            end else if (i_strobe) begin
                if (i_flush) begin
                    // Unfilled upper lanes are still zero from the last clear.
                    r_word <= w_merged;
                    r_we   <= 1'b1;
                    r_buf  <= '0;
                end else begin
                    r_buf <= w_merged;
                end
            end
        end
    end

    assign o_word = r_word;
    assign o_we   = r_we;

endmodule

// File: rtl/boot_loader.sv
// ----------------------------------------------------------------------------
// boot_loader
// UART boot stage: sends READY, receives a 32-bit LE size and the program,
// writes packed words into IMEM, sends ACK, then passes the UART to the CPU.
// Ports:
//   clock, resetn                 clock, synchronous active-low reset
//   rx_ready, rdata, ferr         UartRx strobe, byte, framing error
//   tx_busy, tx_start, sdata      UartTx busy, start strobe, byte
//   imem_we, imem_addr, imem_wdata IMEM word write port
//   boot_done                     load complete, UART belongs to the CPU
//   overflow, frame_err           sticky error flags
//   cpu_tx_start, cpu_sdata       CPU transmit request (after boot)
//   cpu_rx_ready, cpu_rdata       CPU receive side (after boot)
// ----------------------------------------------------------------------------
module boot_loader
    import boot_pkg::*;
#(
    parameter int         IMEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEF,
    parameter logic [7:0] READY_BYTE      = READY_BYTE_DEF,
    parameter logic [7:0] ACK_BYTE        = ACK_BYTE_DEF
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       rx_ready,
    input  logic [7:0]                 rdata,
    input  logic                       ferr,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [7:0]                 sdata,
    output logic                       imem_we,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       boot_done,
    output logic                       overflow,
    output logic                       frame_err,
    input  logic                       cpu_tx_start,
    input  logic [7:0]                 cpu_sdata,
    output logic                       cpu_rx_ready,
    output logic [7:0]                 cpu_rdata
);

    boot_state_t                r_state, w_next_state, r_ret;
    logic [31:0]                r_cnt, r_size;
    logic                       r_prog_done, r_boot_done;
    logic                       r_overflow, r_frame_err;
    logic [IMEM_ADDR_WIDTH-1:0] r_imem_addr;
    logic                       r_wr_drop;

    logic        w_accept, w_byte_in_size, w_byte_in_prog;
    logic [32:0] w_cnt_inc;
    logic        w_last_byte, w_flush, w_addr_oob;
    logic [31:0] w_size_full;
    logic        w_fsm_tx_start;
    logic [7:0]  w_fsm_sdata;
    logic [31:0] w_pk_word;
    logic        w_pk_we;

    assign w_accept       = rx_ready & ~ferr;
    assign w_byte_in_size = (r_state == S_SIZE) & w_accept;
    // Once the final byte is in, later bytes must not disturb the last write.
    assign w_byte_in_prog = (r_state == S_PROG) & w_accept & ~r_prog_done;
    // 33-bit increment so a size of 2^32-1 still terminates correctly.
    assign w_cnt_inc      = {1'b0, r_cnt} + 33'd1;
    assign w_last_byte    = (w_cnt_inc == {1'b0, r_size});
    assign w_flush        = (r_cnt[1:0] == 2'd3) | w_last_byte;
    assign w_size_full    = {rdata, r_size[23:0]};
    assign w_addr_oob     = (r_cnt >> (IMEM_ADDR_WIDTH + 2)) != 32'd0;

    always_ff @(posedge clock) begin
        if (!resetn) r_state <= S_READY;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state   = r_state;
        w_fsm_tx_start = 1'b0;
        w_fsm_sdata    = 8'h00;
        case (r_state)
            S_READY: if (!tx_busy) begin
                w_fsm_tx_start = 1'b1;
                w_fsm_sdata    = READY_BYTE;
                w_next_state   = S_TXWAIT;
            end
            // UartTx raises busy a cycle late, so wait one cycle unconditionally.
            S_TXWAIT: w_next_state = r_ret;
            S_SIZE: if (w_byte_in_size && r_cnt[1:0] == 2'd3)
                w_next_state = (w_size_full == 32'd0) ? S_ACK : S_PROG;
            // r_prog_done is set with the final byte; the write fires this cycle.
            S_PROG: if (r_prog_done) w_next_state = S_ACK;
            S_ACK: if (!tx_busy) begin
                w_fsm_tx_start = 1'b1;
                w_fsm_sdata    = ACK_BYTE;
                w_next_state   = S_TXWAIT;
            end
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_READY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ret       <= S_SIZE;
            r_cnt       <= '0;
            r_size      <= '0;
            r_prog_done <= 1'b0;
            r_boot_done <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
            r_imem_addr <= '0;
            r_wr_drop   <= 1'b0;
        end else begin
            if (r_state == S_READY && !tx_busy) r_ret <= S_SIZE;
            if (r_state == S_ACK && !tx_busy) begin
                r_ret       <= S_DONE;
                r_boot_done <= 1'b1;
            end
            if (rx_ready && ferr && !r_boot_done) r_frame_err <= 1'b1;
            if (w_byte_in_size) begin
                r_size[{r_cnt[1:0], 3'b000} +: 8] <= rdata;
                // Counter restarts at zero for the program phase.
                r_cnt <= (r_cnt[1:0] == 2'd3) ? 32'd0 : r_cnt + 32'd1;
            end
            if (w_byte_in_prog) begin
                r_cnt <= w_cnt_inc[31:0];
                if (w_last_byte) r_prog_done <= 1'b1;
                if (w_flush) begin
                    r_imem_addr <= r_cnt[IMEM_ADDR_WIDTH+1:2];
                    // Out-of-range words are consumed but never written.
                    r_wr_drop   <= w_addr_oob;
                    if (w_addr_oob) r_overflow <= 1'b1;
                end
            end
        end
    end

    word_packer u_packer (
        .clock    (clock),
        .resetn   (resetn),
        .i_strobe (w_byte_in_prog),
        .i_lane   (r_cnt[1:0]),
        .i_byte   (rdata),
        .i_flush  (w_flush),
        .i_clear  (r_state != S_PROG),
        .o_word   (w_pk_word),
        .o_we     (w_pk_we)
    );

    assign imem_we    = w_pk_we & ~r_wr_drop;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = w_pk_word;
    assign boot_done  = r_boot_done;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

    // Combinational UART-side outputs are gated by resetn so they read zero
    // while reset is held, matching the registered outputs.
    assign tx_start     = resetn & (w_fsm_tx_start | (r_boot_done & cpu_tx_start));
    assign sdata        = !resetn ? 8'h00 : (r_boot_done ? cpu_sdata : w_fsm_sdata);
    assign cpu_rx_ready = resetn & r_boot_done & rx_ready;
    assign cpu_rdata    = resetn ? rdata : 8'h00;

endmodule
